// File: rtl/csa_pipe_adder.sv
// Two-stage pipelined carry-select adder/subtractor with valid/ready on both ends.
// Stage 1 precomputes per-segment sums for both carry-in values; stage 2 resolves the select chain.
module csa_pipe_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG = WIDTH / BLOCK;
  localparam logic [BLOCK:0] ONE = {{BLOCK{1'b0}}, 1'b1};

  generate
    if (WIDTH < 2 || (WIDTH % BLOCK) != 0) begin : g_bad_param
      $error("csa_pipe_adder: WIDTH must be >= 2 and a multiple of BLOCK");
    end
  endgenerate

  logic [WIDTH-1:0] bx;
  logic             c_eff;
  logic [WIDTH-1:0] s0_d, s1_d;
  logic [NSEG-1:0]  c0_d, c1_d;

  assign bx    = sub ? ~b : b;
  assign c_eff = sub | cin;

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    assign {c0_d[k], s0_d[k*BLOCK +: BLOCK]} =
      {1'b0, a[k*BLOCK +: BLOCK]} + {1'b0, bx[k*BLOCK +: BLOCK]};
    assign {c1_d[k], s1_d[k*BLOCK +: BLOCK]} =
      {1'b0, a[k*BLOCK +: BLOCK]} + {1'b0, bx[k*BLOCK +: BLOCK]} + ONE;
  end

  logic             s1_valid;
  logic [WIDTH-1:0] s0_q, s1_q;
  logic [NSEG-1:0]  c0_q, c1_q;
  logic             ceff_q, amsb_q, bmsb_q;
  logic             stage2_free, s1_load, s2_load;

  // in_ready looks through to out_ready: no skid buffer, so a full stall holds two ops.
  assign stage2_free = !out_valid || out_ready;
  assign in_ready    = !s1_valid || stage2_free;
  assign s1_load     = in_valid && in_ready;
  assign s2_load     = s1_valid && stage2_free;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s0_q     <= '0;
      s1_q     <= '0;
      c0_q     <= '0;
      c1_q     <= '0;
      ceff_q   <= 1'b0;
      amsb_q   <= 1'b0;
      bmsb_q   <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (s1_load) begin
        s0_q   <= s0_d;
        s1_q   <= s1_d;
        c0_q   <= c0_d;
        c1_q   <= c1_d;
        ceff_q <= c_eff;
        amsb_q <= a[WIDTH-1];
        bmsb_q <= bx[WIDTH-1];
      end
    end
  end

  logic [WIDTH-1:0] sum_d;
  logic             c_run;
  logic             ovf_d;

  always_comb begin
    sum_d = '0;
    c_run = ceff_q;
    for (int k = 0; k < NSEG; k++) begin
      sum_d[k*BLOCK +: BLOCK] = c_run ? s1_q[k*BLOCK +: BLOCK] : s0_q[k*BLOCK +: BLOCK];
      c_run = c_run ? c1_q[k] : c0_q[k];
    end
    ovf_d = (amsb_q == bmsb_q) && (sum_d[WIDTH-1] != amsb_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (stage2_free) out_valid <= s1_valid;
      if (s2_load) begin
        sum  <= sum_d;
        cout <= c_run;
        ovf  <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_csa_pipe_adder.sv
// Bench for csa_pipe_adder: arithmetic scoreboard model plus directed vectors and handshake scenarios.
`timescale 1ns/1ps
module tb_csa_pipe_adder;

  localparam int W = 16;

  logic         clk, rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b;
  logic         cin, sub;
  logic         out_valid, out_ready;
  logic [W-1:0] sum;
  logic         cout, ovf;

  csa_pipe_adder #(.WIDTH(W), .BLOCK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } exp_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } vec_t;

  int   compared   = 0;
  int   mismatched = 0;
  exp_t q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Result from plain integer arithmetic: unsigned range for carry/borrow, signed range for overflow.
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic ci, input logic su);
    exp_t        m;
    int          sa, sb, r;
    int unsigned ua, ub, tot;
    sa = int'($signed(av));
    sb = int'($signed(bv));
    ua = av;
    ub = bv;
    if (su) begin
      r   = sa - sb;
      tot = ua - ub;
      m.c = (ua >= ub);
    end else begin
      r   = sa + sb + int'(ci);
      tot = ua + ub + ci;
      m.c = (tot >= 32'h1_0000);
    end
    m.s = tot[W-1:0];
    m.o = (r > 32767) || (r < -32768);
    return m;
  endfunction

  task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic ci, input logic su);
    int n;
    a = av; b = bv; cin = ci; sub = su; in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("in_ready_wait_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  vec_t plan[7];
  vec_t extra[5];
  logic [15:0] rdy_pat;

  initial begin
    plan[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    plan[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    plan[2] = '{16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    plan[3] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    plan[4] = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    plan[5] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    plan[6] = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    extra[0] = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    extra[1] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    extra[2] = '{16'h0000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1};
    extra[3] = '{16'h0F0F, 16'hF0F0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    extra[4] = '{16'hABCD, 16'hABCD, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    rdy_pat = 16'b1011_0010_1110_0101;

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;

    // Scoreboard: checks every cycle the output is valid, pops on transfer, flushes on reset.
    fork
      forever begin
        @(negedge clk or negedge rst_n);
        if (!rst_n) begin
          q.delete();
        end else begin
          if (out_valid) begin
            if (q.size() == 0) begin
              chk("spurious_out_valid", out_valid, 0);
            end else begin
              chk("sb_sum", sum, q[0].s);
              chk("sb_cout", cout, q[0].c);
              chk("sb_ovf", ovf, q[0].o);
              if (out_ready) void'(q.pop_front());
            end
          end
          if (in_valid && in_ready) q.push_back(model(a, b, cin, sub));
        end
      end
    join_none

    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);

    // Pin the model with hand-computed results.
    foreach (plan[i]) begin
      exp_t m;
      m = model(plan[i].a, plan[i].b, plan[i].cin, plan[i].sub);
      chk($sformatf("model_plan%0d", i), {m.s, m.c, m.o}, {plan[i].s, plan[i].c, plan[i].o});
    end
    foreach (extra[i]) begin
      exp_t m;
      m = model(extra[i].a, extra[i].b, extra[i].cin, extra[i].sub);
      chk($sformatf("model_extra%0d", i), {m.s, m.c, m.o}, {extra[i].s, extra[i].c, extra[i].o});
    end

    #11 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic add: result visible two cycles after the cycle the operands were presented.
    send(16'h00FF, 16'h0001, 1'b0, 1'b0);
    @(negedge clk);
    chk("lat_not_yet", out_valid, 0);
    @(negedge clk);
    chk("lat_valid", out_valid, 1);
    chk("basic_sum", sum, 16'h0100);
    chk("basic_cout", cout, 0);
    chk("basic_ovf", ovf, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1;

    // Back-to-back stream of the plan vectors at full throughput.
    foreach (plan[i]) send(plan[i].a, plan[i].b, plan[i].cin, plan[i].sub);
    repeat (4) @(posedge clk);
    #1;

    // Backpressure: two ops fill the pipe, a third is refused.
    out_ready = 1'b0;
    send(16'h0001, 16'h0001, 1'b0, 1'b0);
    send(16'h0002, 16'h0002, 1'b0, 1'b0);
    a = 16'h0003; b = 16'h0003; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_sum_hold", sum, 16'h0002);
    end
    a = 16'h5A5A; b = 16'hA5A5;
    @(negedge clk);
    chk("bp_sum_hold_inputs_move", sum, 16'h0002);
    @(posedge clk); #1;
    a = 16'h0003; b = 16'h0003;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_out0", sum, 16'h0002);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_out1_valid", out_valid, 1);
    chk("bp_out1", sum, 16'h0004);
    @(negedge clk);
    chk("bp_out2_valid", out_valid, 1);
    chk("bp_out2", sum, 16'h0006);
    @(posedge clk); #1;

    // Stream with an irregular out_ready pattern.
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          out_ready = rdy_pat[i];
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join_none
    foreach (extra[i]) send(extra[i].a, extra[i].b, extra[i].cin, extra[i].sub);
    foreach (plan[i]) send(plan[i].a, plan[i].b, plan[i].cin, plan[i].sub);
    repeat (20) @(posedge clk);
    #1;
    out_ready = 1'b1;

    // Reset mid-flight: both in-flight ops are discarded.
    send(16'hAAAA, 16'h1111, 1'b0, 1'b0);
    send(16'h5555, 16'h2222, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    #0.5 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    send(16'h1234, 16'h1111, 1'b0, 1'b0);
    @(negedge clk);
    chk("postrst_not_yet", out_valid, 0);
    @(negedge clk);
    chk("postrst_valid", out_valid, 1);
    chk("postrst_sum", sum, 16'h2345);
    repeat (3) @(negedge clk);

    begin
      int n;
      n = 0;
      while (q.size() != 0 && n < 100) begin
        n++;
        @(negedge clk);
      end
    end
    chk("queue_drained", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
